mac_acc_drain: RTL and testbench

//  Readout side of the MAC array. Snapshots NUM_MACS signed accumulators once valid, then pulses clear_acc so the array can restart.

---
 rtl/mac_drain_pkg.sv | 17 +
 rtl/mac_requant_sat.sv | 42 ++++
 rtl/mac_acc_drain.sv | 133 +++++++++++++
 tb/tb_mac_acc_drain.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mac_drain_pkg.sv
// Shared types and saturation limits for the MAC accumulator drain path.
package mac_drain_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ACC,
      CAPTURE,
      SEND,
      DONE
   } drain_state_t;

   localparam int INT8_MAX = 127;
   localparam int INT8_MIN = -128;
   localparam int INT4_MAX = 7;
   localparam int INT4_MIN = -8;

endpackage

// File: rtl/mac_requant_sat.sv
// Combinational requantizer: round half up, arithmetic right shift, saturate to INT8 or INT4.
module mac_requant_sat
   import mac_drain_pkg::*;
#(
   parameter int ACC_W   = 20,
   parameter int OUT_W   = 8,
   parameter int SHIFT_W = 5
) (
   input  logic signed [ACC_W-1:0]   acc,
   input  logic        [SHIFT_W-1:0] shift,
   input  logic                      int4,
   output logic signed [OUT_W-1:0]   result
);

   logic signed [ACC_W:0] acc_wide;
   logic signed [ACC_W:0] rnd;
   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] shifted;
   logic signed [ACC_W:0] hi;
   logic signed [ACC_W:0] lo;

   always_comb begin
      acc_wide = {acc[ACC_W-1], acc};
      rnd      = '0;
      if (shift != '0) begin
         rnd = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
      end
      // One guard bit keeps the rounding add from overflowing at full-scale positive input
      sum     = acc_wide + rnd;
      shifted = sum >>> shift;
      hi      = int4 ? (ACC_W+1)'(INT4_MAX) : (ACC_W+1)'(INT8_MAX);
      lo      = int4 ? (ACC_W+1)'(INT4_MIN) : (ACC_W+1)'(INT8_MIN);
      if (shifted > hi) begin
         result = hi[OUT_W-1:0];
      end else if (shifted < lo) begin
         result = lo[OUT_W-1:0];
      end else begin
         result = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/mac_acc_drain.sv
// Drains NUM_MACS accumulators: snapshot, clear pulse, requantize and stream over valid/ready.
// Optional MAC_DRAIN_INT4_EN adds i_int4_mode for INT4 saturation.
module mac_acc_drain
   import mac_drain_pkg::*;
#(
   parameter int NUM_MACS = 4,
   parameter int ACC_W    = 20,
   parameter int OUT_W    = 8,
   parameter int SHIFT_W  = 5
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [SHIFT_W-1:0]            i_shift,
`ifdef MAC_DRAIN_INT4_EN
   input  logic                          i_int4_mode,
`endif
   input  logic [NUM_MACS*ACC_W-1:0]     i_acc_flat,
   input  logic                          i_acc_valid,
   output logic                          o_clear_acc,
   output logic                          o_busy,
   output logic [OUT_W-1:0]              o_data,
   output logic [$clog2(NUM_MACS)-1:0]   o_index,
   output logic                          o_last,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic                          o_done
);

   localparam int IDX_W = $clog2(NUM_MACS);

   drain_state_t              state_reg, state_next;
   logic [SHIFT_W-1:0]        shift_reg;
   logic                      int4_reg;
   logic signed [ACC_W-1:0]   snap [NUM_MACS];
   logic [IDX_W-1:0]          idx_reg;
   logic [IDX_W-1:0]          sel_idx;
   logic [OUT_W-1:0]          data_reg;
   logic                      last_reg;
   logic signed [OUT_W-1:0]   rq_result;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (start) state_next = WAIT_ACC;
         WAIT_ACC: if (i_acc_valid) state_next = CAPTURE;
         CAPTURE:  state_next = SEND;
         SEND:     if (i_ready && last_reg) state_next = DONE;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Outputs decode straight from state so reset clears them without waiting for a clock
   assign o_clear_acc = (state_reg == CAPTURE);
   assign o_busy      = (state_reg != IDLE);
   assign o_valid     = (state_reg == SEND);
   assign o_done      = (state_reg == DONE);
   assign o_data      = data_reg;
   assign o_index     = idx_reg;
   assign o_last      = last_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shift_reg <= '0;
      end else if (state_reg == IDLE && start) begin
         shift_reg <= (i_shift > SHIFT_W'(ACC_W-1)) ? SHIFT_W'(ACC_W-1) : i_shift;
      end
   end

`ifdef MAC_DRAIN_INT4_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         int4_reg <= 1'b0;
      end else if (state_reg == IDLE && start) begin
         int4_reg <= i_int4_mode;
      end
   end
`else
   assign int4_reg = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MACS; gi++) begin : g_snap
         logic signed [ACC_W-1:0] elem_reg;
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               elem_reg <= '0;
            end else if (state_reg == WAIT_ACC && i_acc_valid) begin
               elem_reg <= i_acc_flat[gi*ACC_W +: ACC_W];
            end
         end
         assign snap[gi] = elem_reg;
      end
   endgenerate

   // Shared requantizer looks one element ahead so the next result is ready at the handshake
   assign sel_idx = (state_reg == CAPTURE) ? '0 : idx_reg + IDX_W'(1);

   mac_requant_sat #(
      .ACC_W   (ACC_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
   ) u_requant (
      .acc    (snap[sel_idx]),
      .shift  (shift_reg),
      .int4   (int4_reg),
      .result (rq_result)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_reg <= '0;
         idx_reg  <= '0;
         last_reg <= 1'b0;
      end else if (state_reg == CAPTURE ||
                   (state_reg == SEND && i_ready && !last_reg)) begin
         data_reg <= rq_result;
         idx_reg  <= sel_idx;
         last_reg <= (sel_idx == IDX_W'(NUM_MACS-1));
      end
   end

endmodule

// File: tb/tb_mac_acc_drain.sv
// Directed bench for mac_acc_drain: drain passes, rounding, saturation, back-pressure, abort.
module tb_mac_acc_drain;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [4:0]  i_shift;
`ifdef MAC_DRAIN_INT4_EN
   logic        i_int4_mode;
`endif
   logic [79:0] i_acc_flat;
   logic        i_acc_valid;
   logic        o_clear_acc;
   logic        o_busy;
   logic [7:0]  o_data;
   logic [1:0]  o_index;
   logic        o_last;
   logic        o_valid;
   logic        i_ready;
   logic        o_done;

   int vectors;
   int miscompares;

   mac_acc_drain dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .i_shift     (i_shift),
`ifdef MAC_DRAIN_INT4_EN
      .i_int4_mode (i_int4_mode),
`endif
      .i_acc_flat  (i_acc_flat),
      .i_acc_valid (i_acc_valid),
      .o_clear_acc (o_clear_acc),
      .o_busy      (o_busy),
      .o_data      (o_data),
      .o_index     (o_index),
      .o_last      (o_last),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_done      (o_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_elem(input string name, input int k, input int e);
      check($sformatf("%s valid%0d", name, k), o_valid, 1);
      check($sformatf("%s data%0d", name, k), $signed(o_data), e);
      check($sformatf("%s index%0d", name, k), o_index, k);
      check($sformatf("%s last%0d", name, k), o_last, (k == 3) ? 1 : 0);
      check($sformatf("%s clear%0d", name, k), o_clear_acc, 0);
   endtask

   task automatic run_pass(input string name, input int a[4], input logic [4:0] sh,
                           input int e[4], input int dwell, input int stall_k,
                           input int stall_n, input bit poke_start);
      logic [31:0] tmp;
      for (int k = 0; k < 4; k++) begin
         tmp = a[k];
         i_acc_flat[k*20 +: 20] = tmp[19:0];
      end
      i_shift     = sh;
      i_acc_valid = (dwell == 0);
      start       = 1'b1;
      @(posedge clock); #1;
      start   = 1'b0;
      i_shift = 5'd0;
      check({name, " busy_wait"}, o_busy, 1);
      check({name, " clear_wait"}, o_clear_acc, 0);
      for (int d = 0; d < dwell; d++) begin
         @(posedge clock); #1;
         check({name, " dwell_clear"}, o_clear_acc, 0);
         check({name, " dwell_valid"}, o_valid, 0);
      end
      i_acc_valid = 1'b1;
      @(posedge clock); #1;
      check({name, " clear_cap"}, o_clear_acc, 1);
      check({name, " valid_cap"}, o_valid, 0);
      i_acc_flat  = ~i_acc_flat;
      i_acc_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clock); #1;
         start = 1'b0;
         check_elem(name, k, e[k]);
         $display("%s: elem %0d data %0d index %0d last %0d", name, k, $signed(o_data),
                  o_index, o_last);
         if (poke_start && k == 1) start = 1'b1;
         if (k == stall_k) begin
            i_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               @(posedge clock); #1;
               start = 1'b0;
               check_elem({name, " stall"}, k, e[k]);
            end
            i_ready = 1'b1;
         end
      end
      @(posedge clock); #1;
      check({name, " done"}, o_done, 1);
      check({name, " valid_done"}, o_valid, 0);
      check({name, " busy_done"}, o_busy, 1);
      @(posedge clock); #1;
      check({name, " done_drop"}, o_done, 0);
      check({name, " busy_idle"}, o_busy, 0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      start       = 1'b0;
      i_shift     = 5'd0;
`ifdef MAC_DRAIN_INT4_EN
      i_int4_mode = 1'b0;
`endif
      i_acc_flat  = '0;
      i_acc_valid = 1'b0;
      i_ready     = 1'b1;
      @(posedge clock); #1;
      check("rst valid", o_valid, 0);
      check("rst busy", o_busy, 0);
      check("rst done", o_done, 0);
      check("rst clear", o_clear_acc, 0);
      check("rst data", o_data, 0);
      check("rst index", o_index, 0);
      check("rst last", o_last, 0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      run_pass("T1", '{15, 23, -42, 100}, 5'd0, '{15, 23, -42, 100}, 0, -1, 0, 0);
      run_pass("T2", '{23, -42, 6, -6}, 5'd2, '{6, -10, 2, -1}, 2, -1, 0, 0);
      run_pass("T3a", '{32'h7FFFF, -524288, 300, -300}, 5'd0, '{127, -128, 127, -128},
               0, -1, 0, 0);
      run_pass("T3b", '{32'h7FFFF, -524288, 40, -40}, 5'd4, '{127, -128, 3, -2},
               0, -1, 0, 0);
      run_pass("clamp", '{32'h7FFFF, 32'h40000, -262144, -524288}, 5'd31, '{1, 1, 0, -1},
               0, -1, 0, 0);
      run_pass("T4", '{1, 2, 3, 4}, 5'd0, '{1, 2, 3, 4}, 0, 1, 3, 0);
      run_pass("T5a", '{-1, -2, -3, -4}, 5'd0, '{-1, -2, -3, -4}, 0, -1, 0, 1);
      repeat (2) begin
         @(posedge clock); #1;
         check("T5a no_restart", o_busy, 0);
      end

      // Abort during SEND
      i_acc_flat  = {20'd9, 20'd8, 20'd7, 20'd6};
      i_acc_valid = 1'b1;
      start       = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("T5b pre_valid", o_valid, 1);
      reset_n = 1'b0;
      #1;
      check("T5b abort_valid", o_valid, 0);
      check("T5b abort_busy", o_busy, 0);
      check("T5b abort_done", o_done, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      repeat (3) begin
         @(posedge clock); #1;
         check("T5b no_done", o_done, 0);
         check("T5b idle", o_busy, 0);
      end
      run_pass("T5c", '{50, -60, 70, -80}, 5'd1, '{25, -30, 35, -40}, 0, -1, 0, 0);

`ifdef MAC_DRAIN_INT4_EN
      i_int4_mode = 1'b1;
      run_pass("T6", '{100, -42, 5, -3}, 5'd0, '{7, -8, 5, -3}, 0, -1, 0, 0);
      i_int4_mode = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
